rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single write port of the 32x32 integer register file between several writeback requesters (ALU result, load completion, CSR/misc), granting one per cycle by round-robin. An accepted request is registered and driven onto the register file's write port (we/wa/wdata) the following cycle. Writes to x0 are consumed but never asserted on the port. The block also counts committed writes for performance monitoring.

## Interface
- NREQ, 2, number of writeback requesters (2..4)
- AW, 5, register address width
- DW, 32, write data width
- CW, 16, width of the committed-write counter

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- hold  in  1  pipeline freeze; no grants while high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed destination addresses; requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer on valid & ready
- rf_we  out  1  register file write enable
- rf_wa  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- wr_count  out  CW  count of committed (non-x0) writes

## Operation
- Priority pointer ptr (log2 NREQ bits) names the highest-priority requester. The search order is ptr, ptr+1, … mod NREQ. The first valid requester in that order is granted.
- req_ready is one-hot or zero. It is zero when hold=1, when reset=1, or when no req_valid bit is set.
- On a handshake with requester g:
  - The output stage loads addr and data from requester g.
  - rf_we_next = (addr != 0).
  - ptr <= (g+1) mod NREQ.
- With no handshake, rf_we_next = 0. rf_wa and rf_wdata hold their previous values, and ptr is unchanged.
- A write to x0 is accepted (req_ready pulses) and ptr advances. rf_we stays 0 and wr_count does not increment.
- wr_count increments by 1 in every cycle where rf_we=1. It wraps from 2^CW-1 to 0.
- The output stage never stalls: the register file accepts a write every cycle, so throughput is one write per cycle.
- Requesters hold valid, addr and data stable until ready. Dropping valid before grant is permitted (no transfer).
- Bounded latency: a continuously valid requester is granted within NREQ cycles of hold going low.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wdata=0, wr_count=0, ptr=0. req_ready=0 while reset=1.
- req_ready is combinational from req_valid, ptr, hold and reset. There is no combinational path from req_addr or req_data to any output.
- Latency: handshake in cycle N puts rf_we/rf_wa/rf_wdata at the outputs in cycle N+1. The register file captures the write at the end of cycle N+1.
- rf_we is high for exactly one cycle per accepted non-x0 request.
- Reset asserted mid-operation:
  - A request accepted in the cycle before reset is discarded; rf_we=0 in the cycle after reset is sampled.
  - The requester must re-present any request that was not granted.
- hold rising: the transfer already in the output stage still completes next cycle. No new grant is made while hold=1.
- Simultaneous valid from all requesters with ptr=k: the grant order is k, k+1, … with one grant per cycle and no idle cycles.

## Structure
- Package rf_arb_pkg:
  - localparams REG_AW=5, REG_DW=32, NUM_REGS=32, default NREQ.
  - Function rr_next(ptr, g) returning (g+1) mod NREQ.
- Sub-module rr_pick (combinational):
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant and the encoded index.
  - Reusable for the future read-port arbiter.
- Top level holds ptr, the output stage registers, wr_count and the hold/reset gating.

## Test plan
- Reset with req_valid=2'b11 -> req_ready=0, rf_we=0, wr_count=0. After release, the first grant goes to req 0.
- req0 {addr 5, data 0xDEADBEEF} only -> req_ready=2'b01 in cycle N. Cycle N+1: rf_we=1, rf_wa=5, rf_wdata=0xDEADBEEF, then wr_count=1.
- Both valid continuously for 4 cycles, NREQ=2 -> grants alternate 0,1,0,1. rf_we is high on 4 consecutive cycles and wr_count=4.
- req1 writes addr 0, data 0x1234 -> req_ready[1] pulses and ptr advances to 0. rf_we stays 0 and wr_count is unchanged.
- hold=1 for 3 cycles with req0 valid -> req_ready=0 throughout. Grant in the first cycle after hold falls, rf_we the cycle after that.
- Force wr_count to 0xFFFF, then one committed write -> wr_count wraps to 0x0000.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and round-robin helper for register file port arbiters
package rf_arb_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NUM_REGS = 32;
  localparam int DEF_NREQ = 2;
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned g,
                                          input logic hit, input int unsigned n = DEF_NREQ);
    return hit ? (g + 1) % n : ptr;
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback request bus and register file write port
interface rf_write_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wdata;
  modport master(output req_valid, req_addr, req_data, input req_ready, rf_we, rf_wa, rf_wdata);
  modport slave(input req_valid, req_addr, req_data, output req_ready, rf_we, rf_wa, rf_wdata);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first valid bit at or after ptr
module rr_pick #(
  parameter int N = 2,
  parameter int PW = 1
)(
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] pos [N];
  for (genvar i = 0; i < N; i++) begin : g_pos
    assign pos[i] = PW'((int'(ptr) + i) % N);
  end
  // scan from lowest priority up so the highest-priority hit is written last
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (valid[pos[k]]) begin
        grant = '0;
        grant[pos[k]] = 1'b1;
        idx = pos[k];
      end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register file write port, with a committed-write counter
module rf_write_arbiter import rf_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW,
  parameter int CW = 16
)(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  rf_write_arbiter_if.slave bus,
  output logic [CW-1:0] wr_count
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] grant;
  logic [PW-1:0] idx, ptr;
  logic fire;
  logic [AW-1:0] addr [NREQ];
  logic [DW-1:0] data [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr[i] = bus.req_addr[i*AW +: AW];
    assign data[i] = bus.req_data[i*DW +: DW];
  end
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid(bus.req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
  assign bus.req_ready = (reset || hold) ? '0 : grant;
  assign fire = |bus.req_ready;
  // x0 writes are consumed and still advance ptr, but never raise rf_we
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      bus.rf_we <= 1'b0;
      bus.rf_wa <= '0;
      bus.rf_wdata <= '0;
      wr_count <= '0;
    end else begin
      ptr <= PW'(rr_next(int'(ptr), int'(idx), fire, NREQ));
      bus.rf_we <= fire && addr[idx] != '0;
      bus.rf_wa <= fire ? addr[idx] : bus.rf_wa;
      bus.rf_wdata <= fire ? data[idx] : bus.rf_wdata;
      wr_count <= wr_count + CW'(bus.rf_we);
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table vectors, random traffic against a reference model, counter wrap
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic reset, hold;
  logic [15:0] wr_count;
  rf_write_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) bus();
  rf_write_arbiter #(.NREQ(2), .AW(5), .DW(32), .CW(16)) dut (
    .clk(clk),
    .reset(reset),
    .hold(hold),
    .bus(bus.slave),
    .wr_count(wr_count)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic r, h;
    logic [1:0] v;
    logic [4:0] a0;
    logic [31:0] d0;
    logic [4:0] a1;
    logic [31:0] d1;
    logic [1:0] rdy;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [15:0] cnt;
  } vec_t;

  int passed = 0, total = 0;
  bit quiet;
  logic [1:0] obs_rdy = '0;
  int m_ptr;
  logic m_we;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  logic [15:0] m_cnt;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // first valid requester in the circular order starting at the priority pointer
  function automatic logic [1:0] m_ready(input logic [1:0] v, input logic h, input logic r);
    if (r || h) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (v[(m_ptr + k) % 2]) return 2'b01 << ((m_ptr + k) % 2);
    return 2'b00;
  endfunction

  task automatic step(input logic r, input logic h, input logic [1:0] v, input logic [4:0] a0,
                      input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0] er;
    int g;
    reset = r; hold = h;
    bus.req_valid = v; bus.req_addr = {a1, a0}; bus.req_data = {d1, d0};
    #2;
    obs_rdy = bus.req_ready;
    er = m_ready(v, h, r);
    if (!quiet) chk("req_ready", obs_rdy, er);
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 16'(m_we);
      if (er != 0) begin
        g = er[1] ? 1 : 0;
        m_wa = g ? a1 : a0;
        m_wd = g ? d1 : d0;
        m_we = m_wa != 0;
        m_ptr = (g + 1) % 2;
      end else m_we = 0;
    end
    #1;
    if (!quiet) begin
      chk("rf_we", bus.rf_we, m_we);
      chk("rf_wa", bus.rf_wa, m_wa);
      chk("rf_wdata", bus.rf_wdata, m_wd);
      chk("wr_count", wr_count, m_cnt);
    end
  endtask

  vec_t tbl [19];
  logic [1:0] rv;
  logic [4:0] ra [2];
  logic [31:0] rd [2];

  initial begin
    m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
    tbl = '{
      '{1,0,2'b11, 1,0,          2,0,          2'b00,0, 0,0,          0},
      '{0,0,2'b11, 5,'hDEADBEEF, 6,'h11111111, 2'b01,1, 5,'hDEADBEEF, 0},
      '{0,0,2'b11, 5,'hDEADBEEF, 6,'h11111111, 2'b10,1, 6,'h11111111, 1},
      '{0,0,2'b11, 7,'h70,       8,'h80,       2'b01,1, 7,'h70,       2},
      '{0,0,2'b11, 7,'h70,       8,'h80,       2'b10,1, 8,'h80,       3},
      '{0,0,2'b00, 0,0,          0,0,          2'b00,0, 8,'h80,       4},
      '{0,0,2'b10, 0,0,          0,'h1234,     2'b10,0, 0,'h1234,     4},
      '{0,0,2'b11, 9,'h99,       10,'hAA,      2'b01,1, 9,'h99,       4},
      '{0,1,2'b01, 3,'h33,       0,0,          2'b00,0, 9,'h99,       5},
      '{0,1,2'b01, 3,'h33,       0,0,          2'b00,0, 9,'h99,       5},
      '{0,1,2'b01, 3,'h33,       0,0,          2'b00,0, 9,'h99,       5},
      '{0,0,2'b01, 3,'h33,       0,0,          2'b01,1, 3,'h33,       5},
      '{0,0,2'b00, 0,0,          0,0,          2'b00,0, 3,'h33,       6},
      '{0,0,2'b01, 4,'h44,       0,0,          2'b01,1, 4,'h44,       6},
      '{0,1,2'b10, 0,0,          11,'hBB,      2'b00,0, 4,'h44,       7},
      '{0,0,2'b10, 0,0,          11,'hBB,      2'b10,1, 11,'hBB,      7},
      '{1,0,2'b11, 1,1,          2,2,          2'b00,0, 0,0,          0},
      '{0,0,2'b10, 0,0,          12,'hCC,      2'b10,1, 12,'hCC,      0},
      '{0,0,2'b11, 13,'hDD,      0,0,          2'b01,1, 13,'hDD,      1}
    };
    quiet = 1;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].h, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d_ready", i), obs_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), bus.rf_we, tbl[i].we);
      chk($sformatf("tbl%0d_wa", i), bus.rf_wa, tbl[i].wa);
      chk($sformatf("tbl%0d_wdata", i), bus.rf_wdata, tbl[i].wd);
      chk($sformatf("tbl%0d_count", i), wr_count, tbl[i].cnt);
    end
    quiet = 0;
    rv = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!rv[i] || obs_rdy[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          ra[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
          rd[i] = $urandom;
        end else if ($urandom % 8 == 0) rv[i] = 1'b0;
      step(($urandom % 64) == 0, ($urandom % 8) == 0, rv, ra[0], ra[1], rd[0], rd[1]);
    end
    quiet = 1;
    step(1, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step(0, 0, 2'b01, 5'd1, 5'd0, i, 0);
    chk("count_ffff", wr_count, 16'hFFFF);
    step(0, 0, 2'b00, 0, 0, 0, 0);
    chk("count_wrap", wr_count, 16'h0000);
    chk("we_after_wrap", bus.rf_we, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
